piece_fall_ctrl: RTL

Sequential controller that owns the single falling 16x16 block. It generates the block's pixel position (x_pos, y_pos) and colour, which feed the movable-block renderer directly downstream. It applies gravity from an internal divider and applies left/right moves and soft-drop from debounced keys. It clamps the block to the well interior, signals landing, and respawns the next block with the next colour in sequence.

---
 rtl/tetris_pkg.sv | 46 ++++
 rtl/piece_fall_ctrl_if.sv | 23 ++
 rtl/piece_fall_ctrl_gravity_timer.sv | 37 +++
 rtl/piece_fall_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: palette colours, well geometry and the falling-piece state set.
package tetris_pkg;

  typedef enum logic [2:0] {
    COLOR_NONE   = 3'd0,
    COLOR_LBLUE  = 3'd1,
    COLOR_BLUE   = 3'd2,
    COLOR_ORANGE = 3'd3,
    COLOR_YELLOW = 3'd4,
    COLOR_GREEN  = 3'd5,
    COLOR_PURPLE = 3'd6,
    COLOR_RED    = 3'd7
  } color_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPAWN  = 2'd1,
    FALL   = 2'd2,
    LANDED = 2'd3
  } piece_state_t;

  // Well geometry in pixels; shared with the well-wall renderer.
  localparam logic [10:0] CELL         = 11'd16;
  localparam logic [10:0] WELL_LEFT_X  = 11'd66;
  localparam logic [10:0] WELL_RIGHT_X = 11'd210;
  localparam logic [10:0] WELL_TOP_Y   = 11'd75;
  localparam logic [10:0] WELL_FLOOR_Y = 11'd379;
  localparam logic [10:0] SPAWN_X      = 11'd130;

  // Index of the last entry in the seven-colour spawn sequence.
  localparam logic [2:0] COLOR_SEQ_LAST = 3'd6;

  // Spawn colour for a given position in the sequence.
  function automatic color_t seq_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return COLOR_LBLUE;
      3'd1:    return COLOR_BLUE;
      3'd2:    return COLOR_ORANGE;
      3'd3:    return COLOR_YELLOW;
      3'd4:    return COLOR_GREEN;
      3'd5:    return COLOR_PURPLE;
      default: return COLOR_RED;
    endcase
  endfunction

endpackage

// File: rtl/piece_fall_ctrl_if.sv
// Key inputs and block-position outputs of the falling-piece controller.
interface piece_fall_ctrl_if;
  import tetris_pkg::*;

  logic [3:0]  KEY;
  logic [10:0] x_pos;
  logic [10:0] y_pos;
  color_t      piece_color;
  logic        piece_valid;
  logic        landed;

  // Controller side: reads keys, drives the block.
  modport master (
    input  KEY,
    output x_pos, y_pos, piece_color, piece_valid, landed
  );

  // Renderer / key-source side.
  modport slave (
    output KEY,
    input  x_pos, y_pos, piece_color, piece_valid, landed
  );
endinterface

// File: rtl/piece_fall_ctrl_gravity_timer.sv
// Gravity divider: emits a one-cycle tick every limit cycles, limit shortened while soft-drop is held.
module gravity_timer #(
  parameter int GRAVITY_DIV    = 25_000_000,
  parameter int SOFT_DIV_SHIFT = 3
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  input  logic fast,
  output logic tick
);

  localparam int CW = $clog2(GRAVITY_DIV);
  localparam logic [CW-1:0] SLOW_LAST = CW'(GRAVITY_DIV - 1);
  localparam logic [CW-1:0] FAST_LAST = CW'((GRAVITY_DIV >> SOFT_DIV_SHIFT) - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] last;
  logic          wrap;

  // A counter already past a freshly shortened limit wraps on the very next edge.
  assign last = fast ? FAST_LAST : SLOW_LAST;
  assign wrap = (count >= last);
  assign tick = wrap && !clear;

  // Free-running count, restarted on wrap or when a new piece spawns.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || wrap) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/piece_fall_ctrl.sv
// Falling-block controller: key handling, gravity, wall clamping, landing and colour sequencing.
module piece_fall_ctrl
  import tetris_pkg::*;
#(
  parameter int GRAVITY_DIV    = 25_000_000,
  parameter int SOFT_DIV_SHIFT = 3
) (
  input logic CLOCK_50,
  input logic reset,
  piece_fall_ctrl_if.master bus
);

  logic [3:0]   key_meta;
  logic [3:0]   key_sync;
  logic [3:0]   key_level;
  logic [2:0]   key_level_q;
  logic [2:0]   key_press;
  logic         start_ev;
  logic         left_ev;
  logic         right_ev;
  logic         drop_held;

  piece_state_t state;
  piece_state_t next_state;
  logic [2:0]   color_idx;
  logic [2:0]   idx_d;
  logic [10:0]  x_d;
  logic [10:0]  y_d;
  color_t       color_d;
  logic         valid_d;
  logic         landed_d;

  logic         tick;
  logic         timer_clear;

  // Keys are active-low; after synchronising, a press is the rising edge of the inverted level.
  assign key_level = ~key_sync;
  assign key_press = key_level[2:0] & ~key_level_q;
  assign start_ev  = key_press[0];
  assign left_ev   = key_press[1];
  assign right_ev  = key_press[2];
  assign drop_held = key_level[3];

  // Two-flop synchroniser plus the previous level for edge detection.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_meta    <= 4'hF;
      key_sync    <= 4'hF;
      key_level_q <= 3'b000;
    end else begin
      key_meta    <= bus.KEY;
      key_sync    <= key_meta;
      key_level_q <= key_level[2:0];
    end
  end

  assign timer_clear = (state == SPAWN);

  gravity_timer #(
    .GRAVITY_DIV    (GRAVITY_DIV),
    .SOFT_DIV_SHIFT (SOFT_DIV_SHIFT)
  ) u_gravity (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (timer_clear),
    .fast     (drop_held),
    .tick     (tick)
  );

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: start spawns, a gravity tick at the floor lands, landing respawns.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ev) next_state = SPAWN;
      SPAWN:   next_state = FALL;
      FALL:    if (tick && (bus.y_pos == WELL_FLOOR_Y)) next_state = LANDED;
      LANDED:  next_state = SPAWN;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: next values of the registered block outputs, bounds checked before each step.
  always_comb begin
    x_d      = bus.x_pos;
    y_d      = bus.y_pos;
    color_d  = bus.piece_color;
    valid_d  = bus.piece_valid;
    landed_d = 1'b0;
    idx_d    = color_idx;
    case (state)
      IDLE: begin
        valid_d = 1'b0;
        color_d = COLOR_NONE;
      end
      SPAWN: begin
        x_d     = SPAWN_X;
        y_d     = WELL_TOP_Y;
        color_d = seq_color(color_idx);
        idx_d   = (color_idx == COLOR_SEQ_LAST) ? 3'd0 : color_idx + 3'd1;
        valid_d = 1'b1;
      end
      FALL: begin
        valid_d = 1'b1;
        if (left_ev && !right_ev && (bus.x_pos > WELL_LEFT_X)) begin
          x_d = bus.x_pos - CELL;
        end else if (right_ev && !left_ev && (bus.x_pos < WELL_RIGHT_X)) begin
          x_d = bus.x_pos + CELL;
        end
        if (tick) begin
          if (bus.y_pos < WELL_FLOOR_Y) begin
            y_d = bus.y_pos + CELL;
          end else begin
            landed_d = 1'b1;
          end
        end
      end
      LANDED: begin
        valid_d = 1'b1;
      end
      default: begin
        valid_d = 1'b0;
        color_d = COLOR_NONE;
      end
    endcase
  end

  // Registered outputs and colour index; reset blanks the block immediately.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bus.x_pos       <= SPAWN_X;
      bus.y_pos       <= WELL_TOP_Y;
      bus.piece_color <= COLOR_NONE;
      bus.piece_valid <= 1'b0;
      bus.landed      <= 1'b0;
      color_idx       <= 3'd0;
    end else begin
      bus.x_pos       <= x_d;
      bus.y_pos       <= y_d;
      bus.piece_color <= color_d;
      bus.piece_valid <= valid_d;
      bus.landed      <= landed_d;
      color_idx       <= idx_d;
    end
  end

endmodule
